// File: rtl/noc_pe_adapter.sv
// PE-to-NoC leaf adapter: TX flit FIFO, RX header check and strip, local loopback,
// and round-robin arbitration of network and loopback traffic into one RX register.
module noc_pe_adapter #(
    parameter int unsigned DataWidth = 32,
    parameter logic [7:0]  PeId      = 8'd0,
    parameter int unsigned TxDepth   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [7:0]           i_pe_dest,
    input  logic [23:0]          i_pe_data,
    input  logic                 i_pe_valid,
    output logic                 o_pe_ready,
    output logic [DataWidth-1:0] o_data,
    output logic                 o_data_valid,
    input  logic                 i_data_ready,
    input  logic [DataWidth-1:0] i_data,
    input  logic                 i_data_valid,
    output logic                 o_data_ready,
    output logic [23:0]          o_pe_rx_data,
    output logic                 o_pe_rx_valid,
    input  logic                 i_pe_rx_ready,
    output logic [15:0]          o_misroute_cnt
);

    localparam int unsigned IdW   = 8;
    localparam int unsigned PayW  = 24;
    localparam int unsigned PtrW  = $clog2(TxDepth);
    localparam int unsigned CntW  = 16;

    typedef enum logic {
        GRANT_NET = 1'b0,
        GRANT_LB  = 1'b1
    } grant_e;

    logic [DataWidth-1:0] tx_mem [TxDepth];
    logic [PtrW:0]        wr_ptr, rd_ptr;
    logic                 tx_full, tx_empty;
    logic                 self_req, push_tx, push_lb, pop_tx;
    logic                 lb_full;
    logic [PayW-1:0]      lb_data;
    grant_e               last_grant;
    logic                 match, net_cand, misroute, rx_can_load;
    logic                 grant_net, grant_lb;

    // TX occupancy from wrap-bit pointers
    assign tx_empty = (wr_ptr == rd_ptr);
    assign tx_full  = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                      (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);

    // Send steering; ready looks only at state and destination, never at a same-cycle pop
    assign self_req   = (i_pe_dest == PeId);
    assign o_pe_ready = i_reset_n & (self_req ? ~lb_full : ~tx_full);
    assign push_tx    = i_pe_valid & o_pe_ready & ~self_req;
    assign push_lb    = i_pe_valid & o_pe_ready & self_req;

    assign o_data       = tx_mem[rd_ptr[PtrW-1:0]];
    assign o_data_valid = ~tx_empty;
    assign pop_tx       = o_data_valid & i_data_ready;

    // RX classification and round-robin grant; on contention the source not granted last wins
    assign match       = (i_data[DataWidth-1 -: IdW] == PeId);
    assign net_cand    = i_data_valid & match;
    assign misroute    = i_data_valid & ~match;
    assign rx_can_load = i_reset_n & (~o_pe_rx_valid | i_pe_rx_ready);
    assign grant_net   = rx_can_load & net_cand & (~lb_full | (last_grant == GRANT_LB));
    assign grant_lb    = rx_can_load & lb_full & (~net_cand | (last_grant == GRANT_NET));

    // Misrouted flits are always drained; matching flits only when granted
    assign o_data_ready = i_reset_n & (misroute | grant_net);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            lb_full        <= 1'b0;
            o_pe_rx_valid  <= 1'b0;
            o_misroute_cnt <= '0;
            last_grant     <= GRANT_LB;
        end else begin
            if (push_tx) wr_ptr <= wr_ptr + (PtrW+1)'(1);
            if (pop_tx)  rd_ptr <= rd_ptr + (PtrW+1)'(1);
            lb_full <= push_lb | (lb_full & ~grant_lb);
            if (grant_net || grant_lb) begin
                o_pe_rx_valid <= 1'b1;
                last_grant    <= grant_net ? GRANT_NET : GRANT_LB;
            end else if (i_pe_rx_ready) begin
                o_pe_rx_valid <= 1'b0;
            end
            if (misroute && (o_misroute_cnt != {CntW{1'b1}}))
                o_misroute_cnt <= o_misroute_cnt + CntW'(1);
        end
    end

    // Payload storage needs no reset; valid flags qualify it
    always_ff @(posedge i_clk) begin
        if (push_tx) tx_mem[wr_ptr[PtrW-1:0]] <= {i_pe_dest, i_pe_data};
        if (push_lb) lb_data <= i_pe_data;
        if (grant_net)     o_pe_rx_data <= i_data[PayW-1:0];
        else if (grant_lb) o_pe_rx_data <= lb_data;
    end

endmodule

// File: tb/tb_noc_pe_adapter.sv
// Directed bench for noc_pe_adapter: expected flits/payloads queued by the stimulus,
// popped and compared by an independent monitor on each accepted output.
module tb_noc_pe_adapter;

    localparam logic [7:0] PE_ID = 8'd2;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [7:0]  i_pe_dest;
    logic [23:0] i_pe_data;
    logic        i_pe_valid;
    logic        o_pe_ready;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic        i_data_ready;
    logic [31:0] i_data;
    logic        i_data_valid;
    logic        o_data_ready;
    logic [23:0] o_pe_rx_data;
    logic        o_pe_rx_valid;
    logic        i_pe_rx_ready;
    logic [15:0] o_misroute_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] tx_exp[$];
    logic [23:0] rx_exp[$];

    noc_pe_adapter #(.DataWidth(32), .PeId(PE_ID), .TxDepth(4)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_pe_dest(i_pe_dest), .i_pe_data(i_pe_data), .i_pe_valid(i_pe_valid),
        .o_pe_ready(o_pe_ready),
        .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
        .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
        .o_pe_rx_data(o_pe_rx_data), .o_pe_rx_valid(o_pe_rx_valid),
        .i_pe_rx_ready(i_pe_rx_ready), .o_misroute_cnt(o_misroute_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: every accepted output must match the head of its expectation queue
    always @(negedge i_clk) begin
        if (i_reset_n === 1'b1) begin
            if (o_data_valid && i_data_ready) begin
                if (tx_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected got %h expected none", o_data);
                end else begin
                    chk("tx_flit", o_data, tx_exp.pop_front());
                end
            end
            if (o_pe_rx_valid && i_pe_rx_ready) begin
                if (rx_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx_unexpected got %h expected none", o_pe_rx_data);
                end else begin
                    chk("rx_payload", 32'(o_pe_rx_data), 32'(rx_exp.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset_n = 1'b0; i_pe_dest = '0; i_pe_data = '0; i_pe_valid = 1'b0;
        i_data_ready = 1'b0; i_data = '0; i_data_valid = 1'b0; i_pe_rx_ready = 1'b0;

        // Reset: readies forced low even with traffic offered
        repeat (2) @(posedge i_clk);
        #1;
        i_data = 32'h05ABCDEF; i_data_valid = 1'b1; i_pe_dest = 8'd3; i_pe_valid = 1'b1;
        @(negedge i_clk);
        chk("rst_pe_ready",   32'(o_pe_ready), 32'd0);
        chk("rst_data_ready", 32'(o_data_ready), 32'd0);
        chk("rst_data_valid", 32'(o_data_valid), 32'd0);
        chk("rst_rx_valid",   32'(o_pe_rx_valid), 32'd0);
        chk("rst_cnt",        32'(o_misroute_cnt), 32'd0);
        tick();
        i_data_valid = 1'b0; i_pe_valid = 1'b0; i_reset_n = 1'b1;
        @(negedge i_clk);
        chk("rst_no_push", 32'(o_data_valid), 32'd0);

        // TX burst into a stalled switch: 4 fit, 5th refused
        tick();
        for (int k = 1; k <= 4; k++) begin
            i_pe_dest = 8'd3; i_pe_data = 24'(k); i_pe_valid = 1'b1;
            @(negedge i_clk);
            chk("tx_fill_ready", 32'(o_pe_ready), 32'd1);
            if (o_pe_ready) tx_exp.push_back({8'd3, 24'(k)});
            tick();
        end
        i_pe_data = 24'd5;
        @(negedge i_clk);
        chk("tx_full_ready", 32'(o_pe_ready), 32'd0);
        chk("tx_full_valid", 32'(o_data_valid), 32'd1);
        tick();
        i_data_ready = 1'b1;
        @(negedge i_clk);
        chk("tx_full_pop_ready", 32'(o_pe_ready), 32'd0);
        tick();
        @(negedge i_clk);
        chk("tx_after_pop_ready", 32'(o_pe_ready), 32'd1);
        tx_exp.push_back(32'h03000005);
        tick();
        i_pe_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            chk("tx_stream_valid", 32'(o_data_valid), 32'd1);
            tick();
        end
        @(negedge i_clk);
        chk("tx_drained_valid", 32'(o_data_valid), 32'd0);
        chk("tx_drained_queue", 32'(tx_exp.size()), 32'd0);
        tick();

        // Misroute: drained immediately, counted, never delivered
        i_pe_rx_ready = 1'b1;
        i_data = 32'h05ABCDEF; i_data_valid = 1'b1;
        @(negedge i_clk);
        chk("mis_data_ready", 32'(o_data_ready), 32'd1);
        chk("mis_cnt_before", 32'(o_misroute_cnt), 32'd0);
        tick();
        i_data_valid = 1'b0;
        @(negedge i_clk);
        chk("mis_cnt_after", 32'(o_misroute_cnt), 32'd1);
        chk("mis_rx_valid",  32'(o_pe_rx_valid), 32'd0);
        tick();

        // Matching network flit: header stripped
        rx_exp.push_back(24'hC0FFEE);
        i_data = 32'h02C0FFEE; i_data_valid = 1'b1;
        @(negedge i_clk);
        chk("net_data_ready", 32'(o_data_ready), 32'd1);
        tick();
        i_data_valid = 1'b0;
        chk("net_rx_valid", 32'(o_pe_rx_valid), 32'd1);
        tick();

        // Loopback: lb loads at the first edge, RX output after the second
        rx_exp.push_back(24'h123456);
        i_pe_dest = PE_ID; i_pe_data = 24'h123456; i_pe_valid = 1'b1;
        @(negedge i_clk);
        chk("lb_pe_ready", 32'(o_pe_ready), 32'd1);
        tick();
        i_pe_valid = 1'b0;
        chk("lb_rx_valid_early", 32'(o_pe_rx_valid), 32'd0);
        tick();
        chk("lb_rx_valid",   32'(o_pe_rx_valid), 32'd1);
        chk("lb_rx_data",    32'(o_pe_rx_data), 32'h00123456);
        chk("lb_not_on_tx",  32'(o_data_valid), 32'd0);
        tick();

        // Reset mid-operation: 3 TX entries and a held RX payload are discarded
        i_data_ready = 1'b0; i_pe_rx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_pe_dest = 8'd3; i_pe_data = 24'(32'hA1 + k); i_pe_valid = 1'b1;
            @(negedge i_clk);
            chk("mid_fill_ready", 32'(o_pe_ready), 32'd1);
            if (o_pe_ready) tx_exp.push_back({8'd3, 24'(32'hA1 + k)});
            tick();
        end
        i_pe_valid = 1'b0;
        i_data = 32'h02000777; i_data_valid = 1'b1;
        tick();
        i_data_valid = 1'b0;
        chk("mid_rx_valid", 32'(o_pe_rx_valid), 32'd1);
        chk("mid_tx_valid", 32'(o_data_valid), 32'd1);
        i_reset_n = 1'b0;
        tx_exp.delete();
        rx_exp.delete();
        @(negedge i_clk);
        chk("mid_rst_pe_ready", 32'(o_pe_ready), 32'd0);
        tick();
        chk("mid_rst_tx_valid", 32'(o_data_valid), 32'd0);
        chk("mid_rst_rx_valid", 32'(o_pe_rx_valid), 32'd0);
        chk("mid_rst_cnt",      32'(o_misroute_cnt), 32'd0);
        i_reset_n = 1'b1; i_data_ready = 1'b1; i_pe_rx_ready = 1'b1;
        repeat (4) tick();
        chk("mid_no_stale_tx", 32'(o_data_valid), 32'd0);
        chk("mid_no_stale_rx", 32'(o_pe_rx_valid), 32'd0);

        // Arbitration after reset: network wins first contention, loopback next
        rx_exp.push_back(24'h000BBB);
        rx_exp.push_back(24'h000AAA);
        i_pe_dest = PE_ID; i_pe_data = 24'h000AAA; i_pe_valid = 1'b1;
        tick();
        i_pe_valid = 1'b0;
        i_data = 32'h02000BBB; i_data_valid = 1'b1;
        @(negedge i_clk);
        chk("arb_net_first_ready", 32'(o_data_ready), 32'd1);
        chk("arb_lb_full_ready",   32'(o_pe_ready), 32'd0);
        tick();
        i_data_valid = 1'b0;
        chk("arb_first_data", 32'(o_pe_rx_data), 32'h00000BBB);
        tick();
        chk("arb_second_data", 32'(o_pe_rx_data), 32'h00000AAA);

        // Network granted alone, then loses the next contention and is held
        rx_exp.push_back(24'h000111);
        rx_exp.push_back(24'h000222);
        rx_exp.push_back(24'h000333);
        i_data = 32'h02000111; i_data_valid = 1'b1;
        i_pe_dest = PE_ID; i_pe_data = 24'h000222; i_pe_valid = 1'b1;
        @(negedge i_clk);
        chk("arb_net_alone_ready", 32'(o_data_ready), 32'd1);
        tick();
        i_pe_valid = 1'b0;
        i_data = 32'h02000333;
        @(negedge i_clk);
        chk("arb_net_held", 32'(o_data_ready), 32'd0);
        tick();
        @(negedge i_clk);
        chk("arb_net_released", 32'(o_data_ready), 32'd1);
        tick();
        i_data_valid = 1'b0;
        tick();

        // RX back-pressure holds a matching flit until the register frees
        rx_exp.push_back(24'h000444);
        rx_exp.push_back(24'h000555);
        i_pe_rx_ready = 1'b0;
        i_data = 32'h02000444; i_data_valid = 1'b1;
        @(negedge i_clk);
        chk("bp_first_ready", 32'(o_data_ready), 32'd1);
        tick();
        i_data = 32'h02000555;
        @(negedge i_clk);
        chk("bp_held_ready", 32'(o_data_ready), 32'd0);
        tick();
        i_pe_rx_ready = 1'b1;
        @(negedge i_clk);
        chk("bp_pop_load_ready", 32'(o_data_ready), 32'd1);
        tick();
        i_data_valid = 1'b0;
        repeat (2) tick();

        // Misroute counter saturation
        i_data = 32'h05ABCDEF; i_data_valid = 1'b1;
        repeat (65535) @(posedge i_clk);
        #1;
        chk("sat_reach", 32'(o_misroute_cnt), 32'h0000FFFF);
        @(negedge i_clk);
        chk("sat_data_ready", 32'(o_data_ready), 32'd1);
        tick();
        i_data_valid = 1'b0;
        chk("sat_hold", 32'(o_misroute_cnt), 32'h0000FFFF);
        chk("sat_rx_valid", 32'(o_pe_rx_valid), 32'd0);

        repeat (3) tick();
        chk("end_tx_queue", 32'(tx_exp.size()), 32'd0);
        chk("end_rx_queue", 32'(rx_exp.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_pe_adapter.md
# noc_pe_adapter

Network interface between one processing element (PE) and its leaf port on the 32-bit NoC switch fabric. It turns PE send requests (destination id plus 24-bit payload) into single-flit packets and injects them into the switch through a TxDepth-entry FIFO. It accepts flits ejected by the switch, checks that each flit is addressed to this PE, strips the header and hands the payload to the PE. Traffic addressed to the PE's own id loops back locally and never enters the fabric.

## Interface
- DataWidth, 32, flit width; must be 32. Bits [31:24] are the destination PE id and bits [23:0] are the payload.
- PeId, 0, this PE's 8-bit network id.
- TxDepth, 4, TX FIFO depth; must be a power of 2 and ≥2.
- i_clk  in  1  single clock for all logic.
- i_reset_n  in  1  synchronous, active-low reset.
- i_pe_dest  in  8  destination id of the PE send request.
- i_pe_data  in  24  payload of the PE send request.
- i_pe_valid  in  1  PE send request valid.
- o_pe_ready  out  1  send request accepted this cycle.
- o_data  out  32  flit toward the switch.
- o_data_valid  out  1  flit valid toward the switch.
- i_data_ready  in  1  switch accepts the flit.
- i_data  in  32  flit from the switch.
- i_data_valid  in  1  flit from the switch is valid.
- o_data_ready  out  1  adapter consumes the flit from the switch.
- o_pe_rx_data  out  24  received payload.
- o_pe_rx_valid  out  1  received payload valid; registered.
- i_pe_rx_ready  in  1  PE accepts the received payload.
- o_misroute_cnt  out  16  saturating count of flits received with a destination id other than PeId.

## Operation
- **Send steering**
  - If i_pe_dest == PeId, the request goes to a 1-entry loopback register (lb).
  - Otherwise the request is pushed into the TX FIFO as {i_pe_dest, i_pe_data}.
  - o_pe_ready = reset_n & (dest==PeId ? !lb_full : !tx_full).
  - o_pe_ready depends only on state and i_pe_dest; it never depends on the same-cycle pop.
- **TX FIFO**
  - Pointers are log2(TxDepth)+1 bits and wrap modulo 2·TxDepth. Full means the MSBs differ and the lower bits are equal.
  - o_data is the head entry. o_data_valid = !empty.
  - Pop on o_data_valid & i_data_ready.
  - Simultaneous push and pop when non-full and non-empty: the occupancy is unchanged.
  - Push is refused when full, even if a pop happens in the same cycle.
- **RX classification** of the switch flit:
  - match = i_data[31:24] == PeId.
  - A non-matching flit is consumed immediately: o_data_ready = 1 and o_misroute_cnt increments, saturating at 0xFFFF. It is never delivered to the PE.
  - A matching flit is consumed only when it is granted the RX output register.
- **RX output register**
  - It can load when it is empty or is being popped in the same cycle (o_pe_rx_valid & i_pe_rx_ready).
  - Candidates are the network (i_data_valid & match) and loopback (lb_full).
- **RX arbiter**: round-robin over one last_grant bit, which resets to loopback so that the network wins the first contention.
  - With both candidates present, the source not granted last time wins.
  - With a single candidate, that candidate wins and last_grant updates to it.
  - The loser holds: the network flit sees o_data_ready = 0, and lb stays full.
- **Loopback clear**: lb clears when it is granted. It can reload in the same cycle if the PE pushes a self-addressed request.

## Timing
- Reset (i_reset_n = 0 at a clock edge):
  - Clears the TX pointers, lb_full, o_pe_rx_valid, o_misroute_cnt and last_grant.
  - o_pe_ready and o_data_ready are forced to 0 while i_reset_n is low.
  - o_data_valid = 0 from the first edge with reset low.
  - Any in-flight flits are discarded.
- TX latency: a push at edge N gives o_data_valid = 1 after edge N. A full FIFO streams one flit per cycle.
- RX latency: a matching flit consumed at edge N gives o_pe_rx_valid = 1 after edge N. Sustained throughput is 1 flit/cycle while i_pe_rx_ready = 1.
- Loopback latency: a push at edge N loads lb at N, and the payload appears on o_pe_rx_* after edge N+1 at the earliest.
- Handshake rules:
  - o_data_valid and o_pe_rx_valid, once high, stay high with stable data until accepted.
  - Inputs follow the same rule.
- A misrouted flit is consumed in its arrival cycle regardless of RX register state. The counter increments at most once per cycle.

## Test plan
- **Reset then TX burst**
  - Stimulus: PeId=0, TxDepth=4; with i_data_ready=0, push 5 requests with dest=3 and data 0x000001..0x000005.
  - Required: 4 accepted, o_pe_ready=0 on the 5th.
  - Then raise i_data_ready: o_data gives 0x03000001..0x03000004 on consecutive cycles, then the 5th is accepted.
- **Full plus simultaneous pop**
  - Stimulus: FIFO full, i_data_ready=1, PE pushes in the same cycle.
  - Required: the push is refused that cycle and accepted the next cycle. Order is preserved.
- **Misroute**
  - Stimulus: PeId=2; drive i_data=0x05ABCDEF.
  - Required: o_data_ready=1, o_misroute_cnt 0→1, o_pe_rx_valid stays 0.
  - Preload the count to 0xFFFF and send another: it stays at 0xFFFF.
- **Loopback**
  - Stimulus: PeId=2; push dest=2, data=0x123456.
  - Required: never appears on o_data; o_pe_rx_data=0x123456 with o_pe_rx_valid=1 two edges after the push.
- **Arbitration**
  - Stimulus: lb full (0x000AAA) and network flit 0x02000BBB present in the same cycle, i_pe_rx_ready=1.
  - Required: after reset, 0x000BBB is delivered first and 0x000AAA next cycle, with o_data_ready=0 while the network is held.
- **Reset mid-operation**
  - Stimulus: assert i_reset_n=0 with 3 TX entries and o_pe_rx_valid=1.
  - Required: after the edge, o_data_valid=0, o_pe_rx_valid=0, o_misroute_cnt=0, and no stale flits appear after release.
